// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA: swaps S[i]/S[j], XORs keystream S[S[i]+S[j]] with ROM ciphertext into RAM.
// Optional plaintext filter (lowercase/space only) enabled by defining CHAR_CHECK_EN.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] enc_addr,
  input  logic [7:0]        enc_q,
  output logic [MSG_AW-1:0] dec_addr,
  output logic [7:0]        dec_data,
  output logic              dec_wren,
  output logic              busy,
  output logic              done,
  output logic              key_bad,
  output logic [MSG_AW-1:0] byte_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_INC, S_RD_I, S_LAT_I, S_RD_J, S_LAT_J,
    S_WR_I, S_WR_J, S_RD_F, S_LAT_F, S_WR_D, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d;
  logic [7:0] si_q, si_d, sj_q, sj_d, f_q, f_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [7:0] plain;
  logic last, char_ok;

  assign plain = f_q ^ enc_q;
  assign last  = (k_q == MSG_AW'(MSG_LEN - 1));

`ifdef CHAR_CHECK_EN
  logic key_bad_q, key_bad_d;
  assign char_ok = ((plain >= 8'h61) && (plain <= 8'h7A)) ||
                   (plain == 8'h20);
  assign key_bad = key_bad_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_bad_q <= 1'b0;
    else          key_bad_q <= key_bad_d;
  end
`else
  assign char_ok = 1'b1;
  assign key_bad = 1'b0;
`endif

  assign enc_addr = k_q;
  assign dec_addr = k_q;
  assign byte_idx = k_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      f_q     <= 8'd0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    f_d      = f_q;
    k_d      = k_q;
`ifdef CHAR_CHECK_EN
    key_bad_d = key_bad_q;
`endif
    s_addr   = 8'd0;
    s_data   = 8'd0;
    s_wren   = 1'b0;
    dec_data = 8'd0;
    dec_wren = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_INC;
      end
      S_INC: begin
        i_d     = i_q + 8'd1;
        state_d = S_RD_I;
      end
      S_RD_I: begin
        s_addr  = i_q;
        state_d = S_LAT_I;
      end
      S_LAT_I: begin
        si_d    = s_q;
        j_d     = j_q + s_q;
        state_d = S_RD_J;
      end
      S_RD_J: begin
        s_addr  = j_q;
        state_d = S_LAT_J;
      end
      S_LAT_J: begin
        sj_d    = s_q;
        state_d = S_WR_I;
      end
      S_WR_I: begin
        s_addr  = i_q;
        s_data  = sj_q;
        s_wren  = 1'b1;
        state_d = S_WR_J;
      end
      S_WR_J: begin
        s_addr  = j_q;
        s_data  = si_q;
        s_wren  = 1'b1;
        state_d = S_RD_F;
      end
      S_RD_F: begin
        s_addr  = si_q + sj_q;
        state_d = S_LAT_F;
      end
      S_LAT_F: begin
        f_d     = s_q;
        state_d = S_WR_D;
      end
      S_WR_D: begin
        dec_data = plain;
        if (!char_ok) begin
`ifdef CHAR_CHECK_EN
          key_bad_d = 1'b1;
`endif
          state_d = S_DONE;
        end else begin
          dec_wren = 1'b1;
          if (last) begin
            state_d = S_DONE;
          end else begin
            k_d     = k_q + MSG_AW'(1);
            state_d = S_INC;
          end
        end
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
